// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  localparam logic [3:0] OP_MOVE     = 4'h2;
  localparam logic [3:0] OP_MOVE_FAN = 4'h3;
  localparam logic [3:0] OP_ABORT    = 4'hF;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_DONE = 8'hA5;
  localparam logic [7:0] RESP_STEP = 8'h5A;

endpackage

// File: rtl/tour_move_decode.sv
// Converts a one-hot knight move into its vertical and horizontal move commands.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

  logic [2:0] sel;

  // Lowest set bit wins; an all-zero move falls back to bit 0.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (move[7-i]) sel = 3'(7 - i);
    end
  end

  always_comb begin
    vert_cmd = {OP_MOVE, HDG_N, 4'd2};
    horz_cmd = {OP_MOVE_FAN, HDG_W, 4'd1};
    case (sel)
      3'd0: begin vert_cmd = {OP_MOVE, HDG_N, 4'd2}; horz_cmd = {OP_MOVE_FAN, HDG_W, 4'd1}; end
      3'd1: begin vert_cmd = {OP_MOVE, HDG_N, 4'd2}; horz_cmd = {OP_MOVE_FAN, HDG_E, 4'd1}; end
      3'd2: begin vert_cmd = {OP_MOVE, HDG_N, 4'd1}; horz_cmd = {OP_MOVE_FAN, HDG_W, 4'd2}; end
      3'd3: begin vert_cmd = {OP_MOVE, HDG_S, 4'd1}; horz_cmd = {OP_MOVE_FAN, HDG_W, 4'd2}; end
      3'd4: begin vert_cmd = {OP_MOVE, HDG_S, 4'd2}; horz_cmd = {OP_MOVE_FAN, HDG_W, 4'd1}; end
      3'd5: begin vert_cmd = {OP_MOVE, HDG_S, 4'd2}; horz_cmd = {OP_MOVE_FAN, HDG_E, 4'd1}; end
      3'd6: begin vert_cmd = {OP_MOVE, HDG_S, 4'd1}; horz_cmd = {OP_MOVE_FAN, HDG_E, 4'd2}; end
      default: begin vert_cmd = {OP_MOVE, HDG_N, 4'd1}; horz_cmd = {OP_MOVE_FAN, HDG_E, 4'd2}; end
    endcase
  end

endmodule

// File: rtl/tour_cmd.sv
// Arbitrates the command processor between UART commands and knight's-tour replay.
// Optional feature: define TOUR_ABORT_EN to allow a UART opcode 4'hF to abort a tour.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned LAST_MV = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  state_t      state, nxt;
  logic [15:0] cmd_reg;
  logic [15:0] vert_cmd, horz_cmd;
  logic        tour_rdy;
  logic        load_v, load_h, inc;
  logic        last, in_wait;
  logic        abort_req, abort_hit;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last    = (mv_indx == 5'(LAST_MV));
  assign in_wait = (state == WAIT_V) || (state == WAIT_H);

`ifdef TOUR_ABORT_EN
  assign abort_hit = in_wait && cmd_rdy_UART && (cmd_UART[15:12] == OP_ABORT) && !abort_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             abort_req <= 1'b0;
    else if (nxt == IDLE)   abort_req <= 1'b0;
    else if (abort_hit)     abort_req <= 1'b1;
  end
`else
  assign abort_hit = 1'b0;
  assign abort_req = 1'b0;
`endif

  always_comb begin
    nxt    = state;
    load_v = 1'b0;
    load_h = 1'b0;
    inc    = 1'b0;
    case (state)
      IDLE:   if (start_tour) begin nxt = VERT; load_v = 1'b1; end
      VERT:   if (clr_cmd_rdy) nxt = WAIT_V;
      WAIT_V: if (send_resp) begin
                if (abort_req) nxt = IDLE;
                else begin nxt = HORZ; load_h = 1'b1; end
              end
      HORZ:   if (clr_cmd_rdy) nxt = WAIT_H;
      WAIT_H: if (send_resp) begin
                if (abort_req || last) nxt = IDLE;
                else begin nxt = VERT; load_v = 1'b1; inc = 1'b1; end
              end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mv_indx  <= '0;
      cmd_reg  <= '0;
      tour_rdy <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start_tour) mv_indx <= '0;
      else if (inc)                    mv_indx <= mv_indx + 5'd1;
      if (load_v)      cmd_reg <= vert_cmd;
      else if (load_h) cmd_reg <= horz_cmd;
      if (load_v || load_h) tour_rdy <= 1'b1;
      else if (clr_cmd_rdy) tour_rdy <= 1'b0;
    end
  end

  // A start_tour pulse masks the UART handshake so the pending command survives the tour.
  always_comb begin
    cmd              = cmd_reg;
    cmd_rdy          = tour_rdy;
    clr_cmd_rdy_UART = abort_hit;
    resp             = RESP_STEP;
    if (state == IDLE) begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART & ~start_tour;
      clr_cmd_rdy_UART = clr_cmd_rdy & ~start_tour;
      resp             = RESP_DONE;
    end else if ((state == WAIT_H && last) || (in_wait && abort_req)) begin
      resp = RESP_DONE;
    end
  end

endmodule
